// File: rtl/div_share_arbiter.sv
// Round-robin arbiter that time-shares one iterative divider between NUM_REQ requesters.
// Optional WAIT watchdog: define DIV_ARB_TIMEOUT_EN to bound the wait to TIMEOUT_CYCLES.
module div_share_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 80
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_quotient,
    output logic                          resp_err,
    output logic                          div_start,
    output logic [DATA_WIDTH-1:0]         div_dividend,
    output logic [DATA_WIDTH-1:0]         div_divisor,
    input  logic                          div_done,
    input  logic [DATA_WIDTH-1:0]         div_quotient
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES == 0) begin : gen_bad_cfg
        $error("div_share_arbiter: unsupported parameter values");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         ptr_q, ptr_d;
    logic [IdxW-1:0]         gidx_q, gidx_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      rv_q, rv_d;
    logic [DATA_WIDTH-1:0]   quot_q, quot_d;
    logic                    start_q, start_d;
    logic [DATA_WIDTH-1:0]   dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    logic                  hi_found, lo_found, win_found;
    logic [IdxW-1:0]       hi_idx, lo_idx, win_idx;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [DATA_WIDTH-1:0] win_dvd, win_dvs;

    // Winner is the first request at or above ptr; failing that, wrap to the lowest request.
    always_comb begin
        hi_found   = 1'b0;
        lo_found   = 1'b0;
        hi_idx     = '0;
        lo_idx     = '0;
        win_onehot = '0;
        win_dvd    = '0;
        win_dvs    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req[k]) begin
                if (!hi_found && k >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IdxW'(k);
                end
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IdxW'(k);
                end
            end
        end
        win_found = lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IdxW'(k) == win_idx) begin
                win_onehot[k] = 1'b1;
                win_dvd       = req_dividend[k*DATA_WIDTH +: DATA_WIDTH];
                win_dvs       = req_divisor[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        rv_d    = '0;
        quot_d  = quot_q;
        start_d = 1'b0;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
`ifdef DIV_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gidx_d  = win_idx;
                    gnt_d   = win_onehot;
                    dvd_d   = win_dvd;
                    dvs_d   = win_dvs;
                    start_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
`ifdef DIV_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (div_done) begin
                    quot_d  = div_quotient;
                    rv_d    = gnt_q;
                    state_d = StResp;
`ifdef DIV_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    quot_d  = '0;
                    rv_d    = gnt_q;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
`endif
                end
            end
            StResp: begin
                gnt_d   = '0;
                ptr_d   = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + IdxW'(1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            rv_q    <= '0;
            quot_q  <= '0;
            start_q <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            rv_q    <= rv_d;
            quot_q  <= quot_d;
            start_q <= start_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt           = gnt_q;
    assign resp_valid    = rv_q;
    assign resp_quotient = quot_q;
    assign div_start     = start_q;
    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
`ifdef DIV_ARB_TIMEOUT_EN
    assign resp_err      = err_q;
`else
    assign resp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: vector table, directed corner sequences and random traffic
// against a transaction-level model. Define DIV_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_div_share_arbiter;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int TO = 80;

    logic             clock;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_dividend;
    logic [N*W-1:0]   req_divisor;
    logic [N-1:0]     gnt;
    logic [N-1:0]     resp_valid;
    logic [W-1:0]     resp_quotient;
    logic             resp_err;
    logic             div_start;
    logic [W-1:0]     div_dividend;
    logic [W-1:0]     div_divisor;
    logic             div_done;
    logic [W-1:0]     div_quotient;

    div_share_arbiter #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .gnt           (gnt),
        .resp_valid    (resp_valid),
        .resp_quotient (resp_quotient),
        .resp_err      (resp_err),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int failures;

    // Environment controls
    logic [N-1:0] want;
    bit           auto_drop, drop_all, rand_mode, dv_never;
    int           dv_lat, dv_cnt;
    logic [W-1:0] dv_a, dv_b;

    // Transaction-level model of the arbiter
    bit           m_busy, m_resp, m_err;
    int           m_g, m_ptr, m_age;
    logic [W-1:0] m_dvd, m_dvs, m_q;

    // Inputs as they stood during the cycle that the last edge closed
    logic [N-1:0]   prev_req;
    logic [N*W-1:0] prev_dvd, prev_dvs;
    logic           prev_done;
    logic [W-1:0]   prev_quot;

    typedef struct {
        logic [N-1:0] rq;
        logic [W-1:0] a0, b0, a1, b1;
        int           lat;
        int           exp_g;
        logic [W-1:0] exp_q;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return '1;
        return W'($signed(a) / $signed(b));
    endfunction

    function automatic int rr(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[k*W +: W] = a;
        req_divisor[k*W +: W]  = b;
    endtask

    task automatic rand_ops(input int k);
        logic [W-1:0] mag;
        mag = W'($urandom_range(2, 1000));
        if ($urandom_range(0, 15) == 0) mag = '0;
        set_ops(k, W'($urandom), ($urandom_range(0, 1) == 1) ? (32'd0 - mag) : mag);
    endtask

    task automatic monitor();
        logic [N-1:0] exp_gnt, exp_rv;
        bit           exp_start;
        exp_start = 1'b0;
        if (!m_busy) begin
            if (prev_req != '0) begin
                m_g       = rr(prev_req, m_ptr);
                m_busy    = 1'b1;
                m_resp    = 1'b0;
                m_age     = 0;
                m_dvd     = prev_dvd[m_g*W +: W];
                m_dvs     = prev_dvs[m_g*W +: W];
                exp_start = 1'b1;
            end
        end else if (m_resp) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_ptr  = (m_g + 1) % N;
        end else begin
            if (m_age >= 1 && prev_done) begin
                m_resp = 1'b1;
                m_q    = prev_quot;
                m_err  = 1'b0;
            end
`ifdef DIV_ARB_TIMEOUT_EN
            else if (m_age >= TO) begin
                m_resp = 1'b1;
                m_q    = '0;
                m_err  = 1'b1;
            end
`endif
            m_age++;
        end
        exp_gnt = '0;
        exp_rv  = '0;
        if (m_busy) exp_gnt[m_g] = 1'b1;
        if (m_resp) exp_rv[m_g] = 1'b1;
        chk("mon_gnt", gnt, exp_gnt);
        chk("mon_div_start", div_start, exp_start);
        chk("mon_resp_valid", resp_valid, exp_rv);
        if (exp_start) begin
            chk("mon_div_dividend", div_dividend, m_dvd);
            chk("mon_div_divisor", div_divisor, m_dvs);
        end
        if (m_resp) begin
            chk("mon_resp_quotient", resp_quotient, m_q);
            chk("mon_resp_err", resp_err, m_err);
        end
    endtask

    // One clock: apply this cycle's inputs, pass the edge, check, then react as environment.
    task automatic tick();
        req       = want;
        prev_req  = req;
        prev_dvd  = req_dividend;
        prev_dvs  = req_divisor;
        prev_done = div_done;
        prev_quot = div_quotient;
        @(posedge clock);
        #1;
        if (!reset) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_ptr  = 0;
            m_age  = 0;
        end else begin
            monitor();
        end
        div_done     = 1'b0;
        div_quotient = 32'hDEAD_BEEF;
        if (div_start && !dv_never) begin
            if (rand_mode) dv_lat = $urandom_range(1, 6);
            dv_cnt = dv_lat;
            dv_a   = div_dividend;
            dv_b   = div_divisor;
        end else if (dv_cnt > 0) begin
            dv_cnt--;
            if (dv_cnt == 0) begin
                div_done     = 1'b1;
                div_quotient = ref_div(dv_a, dv_b);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (auto_drop && resp_valid[k]) want[k] = 1'b0;
            if (rand_mode) begin
                if (!want[k] && $urandom_range(0, 3) == 0) begin
                    rand_ops(k);
                    want[k] = 1'b1;
                end else if (want[k] && gnt[k] && $urandom_range(0, 15) == 0) begin
                    want[k] = 1'b0;
                end
                if ($urandom_range(0, 7) == 0) rand_ops(k);
            end
        end
        if (drop_all && resp_valid != '0) want = '0;
    endtask

    task automatic wait_resp(input int bound, output int g, output int lat);
        bit seen;
        seen = 1'b0;
        g    = -1;
        lat  = 0;
        for (int i = 1; i <= bound && !seen; i++) begin
            tick();
            if (resp_valid != '0) begin
                seen = 1'b1;
                lat  = i;
                g    = -2;
                for (int k = 0; k < N; k++) begin
                    if (resp_valid == N'(1 << k)) g = k;
                end
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_resp: no resp_valid within %0d cycles, expected one", bound);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt, '0);
        chk({tag, "_resp_valid"}, resp_valid, '0);
        chk({tag, "_resp_quotient"}, resp_quotient, '0);
        chk({tag, "_resp_err"}, resp_err, '0);
        chk({tag, "_div_start"}, div_start, '0);
        chk({tag, "_div_dividend"}, div_dividend, '0);
        chk({tag, "_div_divisor"}, div_divisor, '0);
    endtask

    initial begin
        int g, lat, rv_cnt, gnt_cnt;
        vecs[0] = '{2'b01, 32'h0000_1400, 32'd5,   32'd0,         32'd1,  10, 0, 32'h0000_0400};
        vecs[1] = '{2'b11, 32'd100,       32'd7,   32'hFFFF_FFEC, 32'd3,  4,  1, 32'hFFFF_FFFA};
        vecs[2] = '{2'b11, 32'd100,       32'd7,   32'hFFFF_FFEC, 32'd3,  3,  0, 32'h0000_000E};
        vecs[3] = '{2'b01, 32'd55,        32'd0,   32'd0,         32'd1,  2,  0, 32'hFFFF_FFFF};
        vecs[4] = '{2'b10, 32'd0,         32'd1,   32'd1000,      32'd10, 1,  1, 32'h0000_0064};
        vecs[5] = '{2'b10, 32'd0,         32'd1,   32'd7,         32'd9,  5,  1, 32'h0000_0000};
        vecs[6] = '{2'b11, 32'h7FFF_FFFF, 32'd2,   32'd8,         32'd2,  4,  0, 32'h3FFF_FFFF};

        checks       = 0;
        failures     = 0;
        want         = '0;
        auto_drop    = 1'b1;
        drop_all     = 1'b1;
        rand_mode    = 1'b0;
        dv_never     = 1'b0;
        dv_lat       = 4;
        dv_cnt       = 0;
        dv_a         = '0;
        dv_b         = '0;
        m_busy       = 1'b0;
        m_resp       = 1'b0;
        m_err        = 1'b0;
        m_g          = 0;
        m_ptr        = 0;
        m_age        = 0;
        m_dvd        = '0;
        m_dvs        = '0;
        m_q          = '0;
        req          = '0;
        req_dividend = '0;
        req_divisor  = '0;
        div_done     = 1'b0;
        div_quotient = '0;
        reset        = 1'b0;

        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            set_ops(0, vecs[v].a0, vecs[v].b0);
            set_ops(1, vecs[v].a1, vecs[v].b1);
            dv_lat = vecs[v].lat;
            want   = vecs[v].rq;
            wait_resp(200, g, lat);
            chk($sformatf("vec%0d_grantee", v), g, vecs[v].exp_g);
            chk($sformatf("vec%0d_quotient", v), resp_quotient, vecs[v].exp_q);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].lat + 2);
            tick();
        end

        // Both requesting from reset: 0, then 1, then 0 again.
        do_reset();
        drop_all = 1'b0;
        set_ops(0, 32'd40, 32'd4);
        set_ops(1, 32'd99, 32'd9);
        dv_lat = 3;
        want   = 2'b11;
        wait_resp(50, g, lat);
        chk("rr_first", g, 0);
        wait_resp(50, g, lat);
        chk("rr_second", g, 1);
        chk("rr_second_quotient", resp_quotient, 32'd11);
        tick();
        want = 2'b11;
        wait_resp(50, g, lat);
        chk("rr_third", g, 0);
        want = '0;
        tick();
        tick();

        // Operand change after grant must not leak into the operation.
        want = 2'b10;
        set_ops(1, 32'd21, 32'd3);
        dv_lat = 6;
        tick();
        tick();
        tick();
        set_ops(1, 32'd21, 32'd7);
        tick();
        chk("hold_divisor", div_divisor, 32'd3);
        wait_resp(50, g, lat);
        chk("hold_grantee", g, 1);
        chk("hold_quotient", resp_quotient, 32'd7);
        tick();

        // Request withdrawn mid-WAIT still completes exactly once.
        want = 2'b01;
        set_ops(0, 32'd64, 32'd8);
        dv_lat = 8;
        tick();
        tick();
        tick();
        want = '0;
        wait_resp(50, g, lat);
        chk("drop_grantee", g, 0);
        chk("drop_quotient", resp_quotient, 32'd8);
        rv_cnt  = 0;
        gnt_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid != '0) rv_cnt++;
            if (gnt != '0) gnt_cnt++;
        end
        chk("drop_extra_resp", rv_cnt, 0);
        chk("drop_extra_gnt", gnt_cnt, 0);

        // Reset during WAIT; the divider finishes after release and must be ignored.
        want = 2'b01;
        set_ops(0, 32'd300, 32'd3);
        dv_lat = 12;
        tick();
        tick();
        tick();
        tick();
        want = '0;
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        tick();
        reset  = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (resp_valid != '0) rv_cnt++;
        end
        chk("stale_done_resp", rv_cnt, 0);

`ifdef DIV_ARB_TIMEOUT_EN
        dv_never = 1'b1;
        set_ops(0, 32'd500, 32'd5);
        want = 2'b01;
        wait_resp(200, g, lat);
        chk("to_grantee", g, 0);
        chk("to_latency", lat, TO + 2);
        chk("to_quotient", resp_quotient, 32'd0);
        chk("to_err", resp_err, 1'b1);
        dv_never = 1'b0;
        tick();
        dv_lat = 4;
        want   = 2'b01;
        wait_resp(50, g, lat);
        chk("after_to_grantee", g, 0);
        chk("after_to_quotient", resp_quotient, 32'd100);
        chk("after_to_err", resp_err, 1'b0);
        tick();
`endif

        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) tick();
        rand_mode = 1'b0;
        want      = '0;
        for (int i = 0; i < 20; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Round-robin arbiter and sequencer that shares one iterative shift-subtract divider between up to NUM_REQ demodulator-side requesters (e.g. the two channel demods' atan ratio step). It latches the winning requester's operands, pulses the divider start, waits for its completion, and returns the quotient to that requester alone. It sits between the demod FSMs and a single divider core, so the divider logic is instantiated only once.

## Interface
- NUM_REQ, 2: number of requesters, 2..4.
- DATA_WIDTH, 32: operand and quotient width, two's complement.
- TIMEOUT_CYCLES, 80: watchdog limit in cycles. Used only with DIV_ARB_TIMEOUT_EN.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester divide request, level.
- req_dividend  in  NUM_REQ*DATA_WIDTH  packed dividends; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_divisor  in  NUM_REQ*DATA_WIDTH  packed divisors, same packing.
- gnt  out  NUM_REQ  one-hot; high from grant until response.
- resp_valid  out  NUM_REQ  one-hot single-cycle result strobe.
- resp_quotient  out  DATA_WIDTH  result; valid only while any resp_valid bit is high.
- resp_err  out  1  timeout flag, qualified by resp_valid. Tied 0 without the macro.
- div_start  out  1  single-cycle start pulse to the divider.
- div_dividend  out  DATA_WIDTH  registered operand.
- div_divisor  out  DATA_WIDTH  registered operand.
- div_done  in  1  divider completion, single cycle.
- div_quotient  in  DATA_WIDTH  divider result; valid when div_done is high.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is high, the arbiter grants the first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - Sets gnt[g].
  - Latches the requester's operands into div_dividend and div_divisor.
  - Goes to ISSUE.
- ISSUE: div_start=1 for exactly this cycle, then goes to WAIT.
- WAIT: on div_done, latches div_quotient into resp_quotient and goes to RESP. div_done seen in any other state is ignored.
- RESP: resp_valid[g]=1 for one cycle.
  - gnt clears on exit.
  - ptr advances to (g+1) mod NUM_REQ.
  - Returns to IDLE.
- Operands are captured only at grant. Later changes to req_dividend or req_divisor do not affect the operation in flight.
- Requesters hold req high until they see resp_valid, and drop it the following cycle. If req is still high in the IDLE cycle after RESP, that counts as a new request.
- If req drops while granted, the operation still completes and resp_valid still pulses. The arbiter does not abort.
- Simultaneous requests: round-robin order from ptr, so no requester is starved. Each requester waits at most NUM_REQ-1 operations.
- Divide-by-zero is passed through to the divider unchanged; its result is returned as-is.
- Reset values: state=IDLE, ptr=0, and every output (gnt, resp_valid, resp_quotient, resp_err, div_start, div_dividend, div_divisor) = 0.
- Reset mid-operation clears all state and outputs immediately. A div_done arriving after reset is released is ignored because the arbiter is in IDLE.

## Timing
- Cycle 0: req sampled in IDLE.
- Cycle 1: gnt high, operands registered, state=ISSUE, div_start high.
- Cycle 2 onward: WAIT.
- div_done in cycle D gives resp_valid in cycle D+1.
- Total latency: D+1 - 0. Back-to-back minimum period is 4 cycles plus the divider latency.
- All outputs are registered; there is no combinational path from req to gnt.

## Configuration
- DIV_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If div_done has not arrived after TIMEOUT_CYCLES cycles, the arbiter goes to RESP with resp_quotient=0 and resp_err=1.
  - A late div_done is ignored.
- DIV_ARB_TIMEOUT_EN undefined: WAIT is unbounded, resp_err is constant 0, and the counter is not synthesized.

## Test plan
- Single request, requester 0, dividend 0x00001400, divisor 0x00000005, model divider returns 0x400 after 10 cycles -> gnt=01 one cycle after req, one div_start pulse, resp_valid=01 one cycle after div_done, resp_quotient=0x400.
- Requests 0 and 1 asserted together from reset -> requester 0 is served first, then 1. A third round with both asserted again serves 0 first (ptr=0 after serving 1).
- Requester 1 changes req_divisor from 3 to 7 during WAIT -> div_divisor stays 3 and the quotient reflects 3.
- Requester drops req mid-WAIT -> resp_valid still pulses once, and the next IDLE grants nothing if no other req is high.
- reset asserted low during WAIT -> all outputs 0 immediately. A stale div_done after release causes no resp_valid.
- With DIV_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=80, divider never asserts done -> resp_valid after 80 WAIT cycles, resp_quotient=0, resp_err=1. The next request is served normally.
